// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: checks 11-bit frames and folds E0/F0 prefixes into make/break events; define PS2_TIMEOUT_EN to abort stalled frames.
// Latency: events appear one clk after the stop-bit falling edge is seen. There is no backpressure, so every event must be taken when event_valid pulses.
module ps2_scancode_rx #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] scancode,
    output logic [15:0] event_code,
    output logic        event_valid,
    output logic        event_break,
    output logic        frame_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic       r_clk_s1;
    logic       r_clk_s2;
    logic       r_clk_prev;
    logic       r_dat_s1;
    logic       r_dat_s2;
    logic       w_fall;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_bitcnt;
    logic [2:0] w_bitcnt_nxt;
    logic [7:0] r_shift;
    logic [7:0] w_shift_nxt;
    logic       r_parity;
    logic       w_parity_nxt;

    logic       w_byte_good;
    logic       w_byte_bad;
    logic       w_tmo_hit;
    logic       w_err;

    logic       r_ext;
    logic       r_brk;
    logic [15:0] w_code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= ps2_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= ps2_data;
            r_dat_s2   <= r_dat_s1;
        end
    end

    assign w_fall = r_clk_prev & ~r_clk_s2;

`ifdef PS2_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] r_tmo_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (w_fall || r_state == S_IDLE) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // A fall in the terminal cycle wins: the frame simply advances.
    assign w_tmo_hit = (r_state != S_IDLE) && !w_fall &&
                       (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_bitcnt <= 3'd0;
            r_shift  <= 8'd0;
            r_parity <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_shift  <= w_shift_nxt;
            r_parity <= w_parity_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_parity_nxt = r_parity;
        w_byte_good  = 1'b0;
        w_byte_bad   = 1'b0;
        if (w_fall) begin
            case (r_state)
                S_IDLE: begin
                    if (!r_dat_s2) begin
                        w_state_nxt  = S_DATA;
                        w_bitcnt_nxt = 3'd0;
                    end
                end
                S_DATA: begin
                    w_shift_nxt  = {r_dat_s2, r_shift[7:1]};
                    w_bitcnt_nxt = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
                        w_state_nxt = S_PARITY;
                    end
                end
                S_PARITY: begin
                    w_parity_nxt = r_dat_s2;
                    w_state_nxt  = S_STOP;
                end
                S_STOP: begin
                    w_state_nxt = S_IDLE;
                    if (r_dat_s2 && (^{r_shift, r_parity})) begin
                        w_byte_good = 1'b1;
                    end else begin
                        w_byte_bad = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end else if (w_tmo_hit) begin
            w_state_nxt = S_IDLE;
        end
    end

    assign w_err  = w_byte_bad | w_tmo_hit;
    assign w_code = {(r_ext ? 8'hE0 : 8'h00), r_shift};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            scancode    <= 16'h0000;
            event_code  <= 16'h0000;
            event_valid <= 1'b0;
            event_break <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            event_valid <= 1'b0;
            frame_err   <= w_err;
            if (w_err) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else if (w_byte_good) begin
                case (r_shift)
                    8'hE0: r_ext <= 1'b1;
                    8'hF0: r_brk <= 1'b1;
                    default: begin
                        event_valid <= 1'b1;
                        event_code  <= w_code;
                        event_break <= r_brk;
                        r_ext       <= 1'b0;
                        r_brk       <= 1'b0;
                        // A release only clears the held code if it is the key being held.
                        if (!r_brk) begin
                            scancode <= w_code;
                        end else if (scancode == w_code) begin
                            scancode <= 16'h0000;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Scoreboard bench for ps2_scancode_rx: directed PS/2 frames, expected events queued ahead of stimulus.
module tb_ps2_scancode_rx;

    localparam int TMO  = 200;
    localparam int HALF = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] scancode;
    logic [15:0] event_code;
    logic        event_valid;
    logic        event_break;
    logic        frame_err;

    typedef struct packed {
        logic        err;
        logic [15:0] code;
        logic        brk;
        logic [15:0] sc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    ps2_scancode_rx #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .scancode   (scancode),
        .event_code (event_code),
        .event_valid(event_valid),
        .event_break(event_break),
        .frame_err  (frame_err)
    );

    task automatic push_ev(input logic [15:0] code, input logic brk, input logic [15:0] sc);
        exp_t e;
        e.err  = 1'b0;
        e.code = code;
        e.brk  = brk;
        e.sc   = sc;
        q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e = '0;
        e.err = 1'b1;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        #(HALF);
        ps2_clk = 1'b0;
        #(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_ok, input logic stop_b);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par_ok ? ~^b : ^b);
        ps2_bit(stop_b);
        ps2_data = 1'b1;
        #(4 * HALF);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b1, 1'b1);
    endtask

    always @(negedge clk) begin
        if (!rst && (event_valid || frame_err)) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output: valid=%0b err=%0b code=%h brk=%0b sc=%h",
                         event_valid, frame_err, event_code, event_break, scancode);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.err) begin
                    if (!(frame_err && !event_valid)) begin
                        bad++;
                        $display("FAIL frame_err: got valid=%0b err=%0b, expected err=1 valid=0",
                                 event_valid, frame_err);
                    end
                end else if (!(event_valid && !frame_err && event_code === e.code &&
                               event_break === e.brk && scancode === e.sc)) begin
                    bad++;
                    $display("FAIL event: got valid=%0b err=%0b code=%h brk=%0b sc=%h, expected code=%h brk=%0b sc=%h",
                             event_valid, frame_err, event_code, event_break, scancode,
                             e.code, e.brk, e.sc);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("reset_scancode", 32'(scancode), 32'h0);
        chk("reset_event_code", 32'(event_code), 32'h0);
        chk("reset_event_valid", 32'(event_valid), 32'h0);
        chk("reset_event_break", 32'(event_break), 32'h0);
        chk("reset_frame_err", 32'(frame_err), 32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // extended make, then extended break
        push_ev(16'hE075, 1'b0, 16'hE075);
        send(8'hE0); send(8'h75);
        push_ev(16'hE075, 1'b1, 16'h0000);
        send(8'hE0); send(8'hF0); send(8'h75);

        // break of a key that is not held leaves scancode alone
        push_ev(16'h001C, 1'b0, 16'h001C);
        send(8'h1C);
        push_ev(16'h001B, 1'b1, 16'h001C);
        send(8'hF0); send(8'h1B);
        push_ev(16'h001C, 1'b1, 16'h0000);
        send(8'hF0); send(8'h1C);

        // parity error drops the byte and clears the pending E0
        push_err();
        send(8'hE0); send_frame(8'h75, 1'b0, 1'b1);
        push_ev(16'h0075, 1'b0, 16'h0075);
        send(8'h75);

        // F0 E0 xx is an extended break; E0 E0 and F0 F0 keep their flag
        push_ev(16'hE075, 1'b1, 16'h0075);
        send(8'hF0); send(8'hE0); send(8'h75);
        push_ev(16'hE074, 1'b0, 16'hE074);
        send(8'hE0); send(8'hE0); send(8'h74);
        push_ev(16'hE074, 1'b0, 16'hE074);
        send(8'hE0); send(8'h74);
        push_ev(16'h001C, 1'b1, 16'hE074);
        send(8'hF0); send(8'hF0); send(8'h1C);

        // missing stop bit
        push_err();
        send_frame(8'h75, 1'b1, 1'b0);

`ifdef PS2_TIMEOUT_EN
        push_err();
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
        ps2_data = 1'b1;
        repeat (TMO + 50) @(posedge clk);
        push_ev(16'h006B, 1'b0, 16'h006B);
        send(8'h6B);
`endif

        // reset in the middle of a frame
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
        @(negedge clk);
        rst = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_scancode", 32'(scancode), 32'h0);
        chk("midrst_event_code", 32'(event_code), 32'h0);
        chk("midrst_event_valid", 32'(event_valid), 32'h0);
        chk("midrst_event_break", 32'(event_break), 32'h0);
        chk("midrst_frame_err", 32'(frame_err), 32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        push_ev(16'hE074, 1'b0, 16'hE074);
        send(8'hE0); send(8'h74);

        repeat (50) @(negedge clk);
        chk("pending_expected", 32'(q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
